regfile_param: RTL and testbench

REGFILE_PARAM -- requirements
Module: regfile_param

---
 rtl/regfile_param.sv | 87 ++++++++
 tb/tb_regfile_param.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_param.sv
// rtl/regfile_param.sv - multi-port register file with array-clear sequencer
// Optional same-cycle write forwarding enabled by defining REGFILE_BYPASS_EN.
module regfile_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREAD*ADDR_W-1:0] ra,
  output logic [NREAD*DATA_W-1:0] rd,
  input  logic                    we,
  input  logic [ADDR_W-1:0]       wa,
  input  logic [DATA_W-1:0]       wd,
  input  logic                    clr,
  output logic                    busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {S_IDLE, S_CLEAR} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              wr_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_CLEAR;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    if (clr) begin
      state_d   = S_CLEAR;
      clr_ptr_d = '0;
    end else if (state_q == S_CLEAR) begin
      // Pointer wraps to zero on the same edge that clears the last entry.
      clr_ptr_d = clr_ptr_q + ADDR_W'(1);
      if (clr_ptr_q == ADDR_W'(DEPTH - 1)) begin
        state_d = S_IDLE;
      end
    end
  end

  assign busy  = (state_q == S_CLEAR);
  assign wr_ok = we && !busy && !((ZERO_REG != 0) && (wa == '0));

  // Storage has no reset; the sequencer zeroes it after rst_n releases.
  always_ff @(posedge clk) begin
    if (busy) begin
      mem_q[clr_ptr_q] <= '0;
    end else if (wr_ok) begin
      mem_q[wa] <= wd;
    end
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra_i;
    logic [DATA_W-1:0] rd_i;

    assign ra_i = ra[i*ADDR_W +: ADDR_W];

    always_comb begin
      rd_i = mem_q[ra_i];
`ifdef REGFILE_BYPASS_EN
      if (wr_ok && (wa == ra_i)) begin
        rd_i = wd;
      end
`endif
      if ((ZERO_REG != 0) && (ra_i == '0)) begin
        rd_i = '0;
      end
    end

    assign rd[i*DATA_W +: DATA_W] = rd_i;
  end

endmodule

// File: tb/tb_regfile_param.sv
// tb/tb_regfile_param.sv - self-checking bench for regfile_param
// Expectations for forwarding follow REGFILE_BYPASS_EN as the RTL is built.
module tb_regfile_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  ra;
  logic [63:0] rd;
  logic        we, clr, busy;
  logic [4:0]  wa;
  logic [31:0] wd;

  logic [2:0]  z_ra, z_wa;
  logic [31:0] z_rd, z_wd;
  logic        z_we, z_clr, z_busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] mdl [32];

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra0, ra1;
    logic [31:0] e0, e1;
  } vec_t;

  vec_t vecs [6];

  always #5 clk = ~clk;

  regfile_param u_dut (
    .clk(clk), .rst_n(rst_n), .ra(ra), .rd(rd), .we(we),
    .wa(wa), .wd(wd), .clr(clr), .busy(busy)
  );

  regfile_param #(.DATA_W(32), .ADDR_W(3), .NREAD(1), .ZERO_REG(0)) u_z0 (
    .clk(clk), .rst_n(rst_n), .ra(z_ra), .rd(z_rd), .we(z_we),
    .wa(z_wa), .wd(z_wd), .clr(z_clr), .busy(z_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts cycles with busy high, starting from the current sample.
  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 200) begin
      n++;
      step();
    end
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  function automatic logic [31:0] ref_read(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (we && !busy && a == wa) return wd;
`endif
    return mdl[a];
  endfunction

  initial begin
    int n;
    int cyc;
    rst_n = 1'b0; ra = '0; we = 1'b0; wa = '0; wd = '0; clr = 1'b0;
    z_ra = '0; z_we = 1'b0; z_wa = '0; z_wd = '0; z_clr = 1'b0;
    foreach (mdl[i]) mdl[i] = 32'h0;

    repeat (3) step();
    chk("busy_in_reset", {31'b0, busy}, 32'h1);
    rst_n = 1'b1;
    count_busy(n);
    chk("reset_clear_len", n, 32);
    for (int a = 0; a < 32; a++) begin
      ra = {a[4:0], a[4:0]};
      #1;
      if (rd !== 64'h0) chk($sformatf("post_reset_zero_%0d", a), rd[31:0] | rd[63:32], 32'h0);
    end
    checks++;

    z_we = 1'b1; z_wa = 3'd0; z_wd = 32'h12345678;
    step();
    z_we = 1'b0; z_ra = 3'd0;
    #1;
    chk("zero_reg0_r0", z_rd, 32'h12345678);

    vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd1,  5'd2, 32'h0,        32'h0};
    vecs[1] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd5, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 5'd0,  32'h12345678, 5'd0,  5'd5, 32'h0,        32'hDEADBEEF};
    vecs[3] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0, 32'h0,        32'h0};
    vecs[4] = '{1'b1, 5'd31, 32'hFFFFFFFF, 5'd5,  5'd30, 32'hDEADBEEF, 32'h0};
    vecs[5] = '{1'b1, 5'd7,  32'h11111111, 5'd31, 5'd0, 32'hFFFFFFFF, 32'h0};
    for (int v = 0; v < 6; v++) begin
      we = vecs[v].we; wa = vecs[v].wa; wd = vecs[v].wd;
      ra = {vecs[v].ra1, vecs[v].ra0};
      #1;
      chk($sformatf("vec%0d_rd0", v), rd[31:0], vecs[v].e0);
      chk($sformatf("vec%0d_rd1", v), rd[63:32], vecs[v].e1);
      if (we && wa != 5'd0) mdl[wa] = wd;
      step();
    end

    we = 1'b1; wa = 5'd7; wd = 32'hA5A5A5A5; ra = {5'd0, 5'd7};
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("bypass_r7", rd[31:0], 32'hA5A5A5A5);
`else
    chk("no_bypass_r7", rd[31:0], 32'h11111111);
`endif
    mdl[7] = 32'hA5A5A5A5;
    step();
    we = 1'b0;
    #1;
    chk("r7_next_cycle", rd[31:0], 32'hA5A5A5A5);

    for (int k = 0; k < 300; k++) begin
      logic [4:0] r0, r1;
      we = $urandom_range(0, 1); wa = $urandom_range(0, 31); wd = $urandom;
      r0 = $urandom_range(0, 31); r1 = (k % 4 == 0) ? wa : 5'($urandom_range(0, 31));
      ra = {r1, r0};
      #1;
      chk("rand_rd0", rd[31:0], ref_read(r0));
      chk("rand_rd1", rd[63:32], ref_read(r1));
      chk("rand_busy", {31'b0, busy}, 32'h0);
      if (we && wa != 5'd0) mdl[wa] = wd;
      step();
    end
    we = 1'b0;

    for (int a = 1; a < 32; a++) begin
      we = 1'b1; wa = a[4:0]; wd = a;
      step();
    end
    we = 1'b0;
    pulse_clr();
    cyc = 1;
    while (busy && cyc < 100) begin
      we = 1'b0;
      if (cyc == 1)  begin we = 1'b1; wa = 5'd3; wd = 32'hFF; end
      if (cyc == 10) begin we = 1'b1; wa = 5'd2; wd = 32'hFF; end
      ra = {5'd2, 5'd10};
      #1;
      if (cyc == 5) begin
        chk("clear_r10_old", rd[31:0], 32'd10);
        chk("clear_r2_zero", rd[63:32], 32'h0);
      end
      step();
      cyc++;
    end
    we = 1'b0;
    chk("clr_len", cyc - 1, 32);
    for (int a = 0; a < 32; a++) begin
      ra = {a[4:0], a[4:0]};
      #1;
      chk($sformatf("after_clr_%0d", a), rd[31:0] | rd[63:32], 32'h0);
    end

    pulse_clr();
    cyc = 1;
    while (busy && cyc < 200) begin
      clr = (cyc == 20);
      step();
      cyc++;
    end
    clr = 1'b0;
    chk("restart_len", cyc - 1, 52);

    pulse_clr();
    repeat (10) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_busy", {31'b0, busy}, 32'h1);
    step();
    rst_n = 1'b1;
    count_busy(n);
    chk("reset_midclear_len", n, 32);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
